// File: rtl/cla_serial_addsub.sv
// rtl/cla_serial_addsub.sv - WIDTH-bit add/sub reusing one 4-bit CLA slice per nibble
module cla_serial_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0]  LAST     = IDXW'(NIB - 1);
    localparam logic [WIDTH-1:0] NIB_MASK = WIDTH'(4'hF);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [IDXW-1:0]  idx;
    logic [IDXW+1:0]  shamt;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       g;
    logic [3:0]       p;
    logic             c1, c2, c3, c4;
    logic [3:0]       sum;
    logic [WIDTH-1:0] res_next;

    assign shamt = {idx, 2'b00};
    assign a_nib = 4'(a_q >> shamt);
    assign b_nib = 4'(b_q >> shamt);
    assign g     = a_nib & b_nib;
    assign p     = a_nib ^ b_nib;

    // Lookahead carries: every carry is a flat function of g, p and the incoming carry.
    assign c1 = g[0] | (p[0] & carry_q);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q);
    assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & carry_q);
    assign sum = p ^ {c3, c2, c1, carry_q};

    // Result with the current nibble replaced; untouched nibbles keep their old contents.
    assign res_next = (result & ~(NIB_MASK << shamt)) | (WIDTH'(sum) << shamt);

    assign ready = (state != S_RUN);
    assign done  = (state == S_DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a start is accepted whenever the block is not mid-run.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (idx == LAST) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_RUN;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Operand latch, per-nibble accumulation and final flag capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            result  <= '0;
            c_out   <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            carry_q <= sub;
            idx     <= '0;
        end else if (state == S_RUN) begin
            result  <= res_next;
            carry_q <= c4;
            idx     <= idx + 1'b1;
            if (idx == LAST) begin
                c_out <= c4;
                ovf   <= c3 ^ c4;
                zero  <= (res_next == '0);
            end
        end
    end

endmodule
